// File: rtl/tau_pkg.sv
// Shared definitions for the tau processor front end.
package tau_pkg;

    localparam int unsigned WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: program RAM read port, instruction handshake and jump redirect.
interface instruction_fetch_unit_if
    import tau_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = WORD_SIZE
);
    logic [ADDRESS_WIDTH-1:0] p_ram_address;
    logic                     p_ram_read_enable;
    logic [DATA_WIDTH-1:0]    p_ram_data;
    logic [DATA_WIDTH-1:0]    instruction;
    logic [ADDRESS_WIDTH-1:0] instruction_address;
    logic                     instruction_valid;
    logic                     instruction_ready;
    logic                     jump_valid;
    logic [ADDRESS_WIDTH-1:0] jump_address;

    modport master (
        output p_ram_address, p_ram_read_enable,
        output instruction, instruction_address, instruction_valid,
        input  p_ram_data, instruction_ready, jump_valid, jump_address
    );

    modport slave (
        input  p_ram_address, p_ram_read_enable,
        input  instruction, instruction_address, instruction_valid,
        output p_ram_data, instruction_ready, jump_valid, jump_address
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter: async reset to RESET_VECTOR, load (priority) or wrap-around increment.
module fetch_pc #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     increment_i,
    input  logic [ADDRESS_WIDTH-1:0] load_value_i,
    output logic [ADDRESS_WIDTH-1:0] pc_o
);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_value_i;
        end else if (increment_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues one-cycle-latency program RAM reads at the PC and holds the word
// behind a valid/ready handshake; a jump redirects the PC and discards any pending word.
module instruction_fetch_unit
    import tau_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = WORD_SIZE,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    output logic [ADDRESS_WIDTH-1:0] program_counter,
    instruction_fetch_unit_if.master fetch_bus
);
    fetch_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] iaddr_q, iaddr_d;
    logic                     pc_load;
    logic                     pc_increment;
    logic                     read_enable;

    fetch_pc #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_fetch_pc (
        .clock       (clock),
        .reset       (reset),
        .load_i      (pc_load),
        .increment_i (pc_increment),
        .load_value_i(fetch_bus.jump_address),
        .pc_o        (program_counter)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        iaddr_d      = iaddr_q;
        pc_load      = 1'b0;
        pc_increment = 1'b0;
        read_enable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = ISSUE;
            end
            ISSUE: begin
                read_enable = enable;
                state_d     = enable ? WAIT : IDLE;
            end
            WAIT: begin
                instr_d      = fetch_bus.p_ram_data;
                iaddr_d      = program_counter;
                pc_increment = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                // Prefetch on the handshake cycle keeps a 2-cycle cadence; a jump suppresses it.
                if (fetch_bus.instruction_ready) begin
                    read_enable = enable & ~fetch_bus.jump_valid;
                    state_d     = enable ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Jump overrides everything: the in-flight read is never latched.
        if (fetch_bus.jump_valid) begin
            instr_d      = instr_q;
            iaddr_d      = iaddr_q;
            pc_increment = 1'b0;
            pc_load      = 1'b1;
            state_d      = enable ? ISSUE : IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            iaddr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
        end
    end

    assign fetch_bus.p_ram_address       = program_counter;
    assign fetch_bus.p_ram_read_enable   = read_enable;
    assign fetch_bus.instruction         = instr_q;
    assign fetch_bus.instruction_address = iaddr_q;
    assign fetch_bus.instruction_valid   = (state_q == HOLD);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random enable/ready/jump traffic,
// with delivered words scored against an address-stream reference model.
module tb_instruction_fetch_unit;
    import tau_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam logic [AW-1:0] RV = 16'h0000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] program_counter;

    instruction_fetch_unit_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instruction_fetch_unit #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .RESET_VECTOR (RV)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .program_counter(program_counter),
        .fetch_bus      (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int accepted = 0;
    logic [DW-1:0] salt;
    logic [DW-1:0] mem_init [logic [AW-1:0]];
    exp_t exp_q [$];

    // Program RAM contents: a few fixed words, everything else a salted hash of the address.
    function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return 16'(a * 16'h9E37) ^ 16'h5A5A ^ salt;
    endfunction

    task automatic push_expected(input logic [AW-1:0] a);
        exp_t e;
        e.addr = a;
        e.data = model_word(a);
        exp_q.push_back(e);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One-cycle-latency synchronous program RAM
    always @(posedge clock) begin
        if (bus.p_ram_read_enable) bus.p_ram_data <= model_word(bus.p_ram_address);
    end

    // Monitor/predictor: inputs are stable by the falling edge, so a handshake seen here
    // happens on the next rising edge. Delivered words form a consecutive address stream
    // that restarts at each jump target.
    always @(negedge clock) begin
        exp_t e;
        logic handshake;
        if (!reset) begin
            handshake = bus.instruction_valid && bus.instruction_ready;
            if (handshake) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    check1("sb_unexpected_word", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check16("sb_addr", bus.instruction_address, e.addr);
                    check16("sb_data", bus.instruction, e.data);
                    if (!bus.jump_valid) push_expected(e.addr + 16'd1);
                end
            end
            if (bus.jump_valid) begin
                exp_q.delete();
                push_expected(bus.jump_address);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        bus.instruction_ready = 1'b0;
        bus.jump_valid = 1'b0;
        exp_q.delete();
        push_expected(RV);
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.instruction_valid) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) check1("wait_valid_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        salt = 16'($urandom());
        mem_init[16'h0000] = 16'h1203;
        mem_init[16'h0001] = 16'h3401;
        mem_init[16'h0002] = 16'h0800;
        mem_init[16'hFFFF] = 16'hABCD;
        bus.instruction_ready = 1'b0;
        bus.jump_valid = 1'b0;
        bus.jump_address = '0;
        exp_q.delete();
        push_expected(RV);
        repeat (2) step();

        check1("rst_valid", bus.instruction_valid, 1'b0);
        check16("rst_instr", bus.instruction, 16'h0000);
        check16("rst_iaddr", bus.instruction_address, 16'h0000);
        check16("rst_pc", program_counter, RV);
        check1("rst_rd_en", bus.p_ram_read_enable, 1'b0);

        // First fetch latency and streaming with ready held high
        reset = 1'b0;
        enable = 1'b1;
        bus.instruction_ready = 1'b1;
        step();
        check1("e1_valid", bus.instruction_valid, 1'b0);
        check1("issue_rd_en", bus.p_ram_read_enable, 1'b1);
        check16("issue_addr", bus.p_ram_address, 16'h0000);
        step();
        check1("e2_valid", bus.instruction_valid, 1'b0);
        check1("wait_rd_en", bus.p_ram_read_enable, 1'b0);
        step();
        check1("e3_valid", bus.instruction_valid, 1'b1);
        check16("e3_instr", bus.instruction, 16'h1203);
        step();
        check1("stream_gap_valid", bus.instruction_valid, 1'b0);
        step();
        check16("e5_instr", bus.instruction, 16'h3401);
        repeat (2) step();
        check16("e7_instr", bus.instruction, 16'h0800);
        check16("e7_pc", program_counter, 16'd3);

        // Backpressure holds the word; raising ready prefetches address 1 combinationally
        do_reset();
        enable = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            check1("stall_valid", bus.instruction_valid, 1'b1);
            check16("stall_instr", bus.instruction, 16'h1203);
            check16("stall_iaddr", bus.instruction_address, 16'h0000);
            check1("stall_rd_en", bus.p_ram_read_enable, 1'b0);
            step();
        end
        bus.instruction_ready = 1'b1;
        #1;
        check1("ready_rd_en", bus.p_ram_read_enable, 1'b1);
        check16("ready_addr", bus.p_ram_address, 16'h0001);
        step();

        // Jump during WAIT of address 1
        bus.jump_valid = 1'b1;
        bus.jump_address = 16'h0020;
        step();
        bus.jump_valid = 1'b0;
        check1("jmp_e1_valid", bus.instruction_valid, 1'b0);
        step();
        check1("jmp_e2_valid", bus.instruction_valid, 1'b0);
        step();
        check1("jmp_valid", bus.instruction_valid, 1'b1);
        check16("jmp_iaddr", bus.instruction_address, 16'h0020);
        check16("jmp_instr", bus.instruction, model_word(16'h0020));

        // PC wrap at all-ones
        bus.instruction_ready = 1'b0;
        bus.jump_valid = 1'b1;
        bus.jump_address = 16'hFFFF;
        step();
        bus.jump_valid = 1'b0;
        step();
        wait_valid(10);
        check16("wrap_instr", bus.instruction, 16'hABCD);
        check16("wrap_iaddr", bus.instruction_address, 16'hFFFF);
        check16("wrap_pc", program_counter, 16'h0000);
        bus.instruction_ready = 1'b1;
        #1;
        check1("wrap_rd_en", bus.p_ram_read_enable, 1'b1);
        check16("wrap_next_addr", bus.p_ram_address, 16'h0000);
        step();

        // Enable dropped during WAIT: the read still completes
        enable = 1'b0;
        bus.instruction_ready = 1'b0;
        step();
        check1("dis_valid", bus.instruction_valid, 1'b1);
        check16("dis_instr", bus.instruction, 16'h1203);
        check16("dis_iaddr", bus.instruction_address, 16'h0000);
        check16("dis_pc", program_counter, 16'h0001);
        bus.instruction_ready = 1'b1;
        #1;
        check1("dis_hs_rd_en", bus.p_ram_read_enable, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            check1("idle_valid", bus.instruction_valid, 1'b0);
            check1("idle_rd_en", bus.p_ram_read_enable, 1'b0);
            check16("idle_pc", program_counter, 16'h0001);
            step();
        end
        enable = 1'b1;
        step();
        check1("resume_rd_en", bus.p_ram_read_enable, 1'b1);
        check16("resume_addr", bus.p_ram_address, 16'h0001);
        wait_valid(5);
        check16("resume_iaddr", bus.instruction_address, 16'h0001);
        bus.instruction_ready = 1'b0;

        // Asynchronous reset mid-HOLD takes effect before the next edge
        #2;
        reset = 1'b1;
        #1;
        check1("arst_valid", bus.instruction_valid, 1'b0);
        check16("arst_pc", program_counter, RV);
        exp_q.delete();
        push_expected(RV);
        repeat (2) step();
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(99) < 85);
            bus.instruction_ready = ($urandom_range(99) < 70);
            bus.jump_valid = ($urandom_range(99) < 5);
            if ($urandom_range(3) == 0)
                bus.jump_address = 16'($urandom_range(16'hFFFF, 16'hFFF0));
            else
                bus.jump_address = 16'($urandom());
            if ($urandom_range(999) < 3) do_reset();
            else step();
        end
        check1("random_progress", accepted > 300, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
